// File: rtl/rat_ckpt_if.sv
// rat_ckpt_if: decode-side, free-list, dispatch-side and commit/recovery
// signals of the checkpointing register alias table.
interface rat_ckpt_if #(
   parameter int RENAME_WIDTH = 4,
   parameter int ARF_SIZE     = 32,
   parameter int PRF_SIZE     = 64,
   parameter int CP_DEPTH     = 8,
   parameter int COMMIT_WIDTH = 4
);
   localparam int AW  = $clog2(ARF_SIZE);
   localparam int PW  = $clog2(PRF_SIZE);
   localparam int CW  = $clog2(CP_DEPTH);
   localparam int FPW = $clog2(RENAME_WIDTH) + 1;
   localparam int RLW = $clog2(COMMIT_WIDTH) + 1;

   // decode -> rename
   logic                       in_valid;
   logic                       in_ready;
   logic [RENAME_WIDTH-1:0]    in_uop_valid;
   logic [RENAME_WIDTH-1:0]    in_rd_valid;
   logic [RENAME_WIDTH-1:0]    in_is_br;
   logic [RENAME_WIDTH*AW-1:0] in_rs1;
   logic [RENAME_WIDTH*AW-1:0] in_rs2;
   logic [RENAME_WIDTH*AW-1:0] in_rd;
   // free list
   logic [RENAME_WIDTH*PW-1:0] fl_prd;
   logic [PW:0]                fl_count;
   logic [FPW-1:0]             fl_pop;
   // rename -> dispatch
   logic                       out_valid;
   logic                       out_ready;
   logic [RENAME_WIDTH-1:0]    out_uop_valid;
   logic [RENAME_WIDTH*PW-1:0] out_prs1;
   logic [RENAME_WIDTH*PW-1:0] out_prs2;
   logic [RENAME_WIDTH*PW-1:0] out_prd;
   logic [RENAME_WIDTH*PW-1:0] out_prev_prd;
   logic [RENAME_WIDTH-1:0]    out_prev_valid;
   logic [RENAME_WIDTH*CW-1:0] out_cp_idx;
   // commit / recovery
   logic [RLW-1:0]             cp_release;
   logic                       recover;
   logic [CW-1:0]              recover_cp;

   modport master (
      output in_valid, in_uop_valid, in_rd_valid, in_is_br, in_rs1, in_rs2, in_rd,
      output fl_prd, fl_count, out_ready, cp_release, recover, recover_cp,
      input  in_ready, fl_pop, out_valid, out_uop_valid, out_prs1, out_prs2,
      input  out_prd, out_prev_prd, out_prev_valid, out_cp_idx
   );

   modport slave (
      input  in_valid, in_uop_valid, in_rd_valid, in_is_br, in_rs1, in_rs2, in_rd,
      input  fl_prd, fl_count, out_ready, cp_release, recover, recover_cp,
      output in_ready, fl_pop, out_valid, out_uop_valid, out_prs1, out_prs2,
      output out_prd, out_prev_prd, out_prev_valid, out_cp_idx
   );
endinterface

// File: rtl/rat_ckpt.sv
// rat_ckpt: multi-wide register alias table with a circular buffer of full
// map-table checkpoints taken at every branch and single-cycle restore.
// Optional macro RAT_CKPT_PERF_EN adds saturating stall counters
// perf_stall_cp_o / perf_stall_fl_o.

// Ring-integrity checker: commit must never free more checkpoints than live.
module rat_ckpt_chk #(
   parameter int CW  = 3,
   parameter int RLW = 3
) (
   input logic           clk_i,
   input logic           rst_i,
   input logic [RLW-1:0] cp_release_i,
   input logic [CW:0]    count_i
);
   a_release_le_count : assert property (@(posedge clk_i) disable iff (rst_i)
      int'(cp_release_i) <= int'(count_i));
endmodule

module rat_ckpt #(
   parameter int RENAME_WIDTH = 4,
   parameter int ARF_SIZE     = 32,
   parameter int PRF_SIZE     = 64,
   parameter int CP_DEPTH     = 8,
   parameter int COMMIT_WIDTH = 4
) (
   input logic         clock_i,
   input logic         reset_i,
   rat_ckpt_if.slave   bus
`ifdef RAT_CKPT_PERF_EN
   ,
   output logic [31:0] perf_stall_cp_o,
   output logic [31:0] perf_stall_fl_o
`endif
);
   localparam int AW  = $clog2(ARF_SIZE);
   localparam int PW  = $clog2(PRF_SIZE);
   localparam int CW  = $clog2(CP_DEPTH);
   localparam int FPW = $clog2(RENAME_WIDTH) + 1;

   typedef logic [ARF_SIZE-1:0][PW-1:0] map_t;

   map_t                            map_q;
   map_t                            cp_q [CP_DEPTH];
   logic [CW-1:0]                   head_q;
   logic [CW:0]                     count_q;
   logic                            out_valid_q;
   logic [FPW-1:0]                  fl_pop_q;
   logic [RENAME_WIDTH-1:0]         uop_valid_q, prev_valid_q;
   logic [RENAME_WIDTH-1:0][PW-1:0] prs1_q, prs2_q, prd_q, prev_q;
   logic [RENAME_WIDTH-1:0][CW-1:0] cp_idx_q;

   map_t                            map_s;
   map_t                            snap_s [RENAME_WIDTH];
   logic [RENAME_WIDTH-1:0]         br_s, prev_valid_s;
   logic [RENAME_WIDTH-1:0][PW-1:0] prs1_s, prs2_s, prd_s, prev_s;
   logic [RENAME_WIDTH-1:0][CW-1:0] cp_idx_s;
   logic [FPW-1:0]                  nw_s, nb_s;
   logic [CW-1:0]                   alloc_base_s, head_rel_s, rec_dist_s;
   logic [CW:0]                     count_rel_s;
   logic [CW+1:0]                   cp_space_s;
   logic                            fl_ok_s, cp_ok_s, out_ok_s, in_ready_s, accept_s;

   // Release is applied before recovery/allocation in the same cycle; the
   // next free slot (head+count) is unaffected by release.
   assign alloc_base_s = head_q + count_q[CW-1:0];
   assign head_rel_s   = head_q + CW'(bus.cp_release);
   assign count_rel_s  = count_q - (CW+1)'(bus.cp_release);
   assign rec_dist_s   = bus.recover_cp - head_rel_s;
   assign cp_space_s   = (CW+2)'(CP_DEPTH) - (CW+2)'(count_q) + (CW+2)'(bus.cp_release);

   assign fl_ok_s    = ((PW+1)'(nw_s) <= bus.fl_count);
   assign cp_ok_s    = ((CW+2)'(nb_s) <= cp_space_s);
   assign out_ok_s   = ~out_valid_q | bus.out_ready;
   assign in_ready_s = ~bus.recover & out_ok_s & fl_ok_s & cp_ok_s;
   assign accept_s   = bus.in_valid & in_ready_s;

   // Rename the group in slot order with intra-group bypass and per-branch snapshots.
   always_comb begin
      map_s        = map_q;
      nw_s         = '0;
      nb_s         = '0;
      prs1_s       = '0;
      prs2_s       = '0;
      prd_s        = '0;
      prev_s       = '0;
      prev_valid_s = '0;
      cp_idx_s     = '0;
      br_s         = '0;
      for (int k = 0; k < RENAME_WIDTH; k++) begin
         snap_s[k] = map_q;
      end
      for (int k = 0; k < RENAME_WIDTH; k++) begin
         if (bus.in_uop_valid[k]) begin
            prs1_s[k] = map_s[bus.in_rs1[k*AW +: AW]];
            prs2_s[k] = map_s[bus.in_rs2[k*AW +: AW]];
            // x0 is hard-wired to p0 and never allocates.
            if (bus.in_rd_valid[k] && (bus.in_rd[k*AW +: AW] != AW'(0))) begin
               prev_s[k]                    = map_s[bus.in_rd[k*AW +: AW]];
               prd_s[k]                     = bus.fl_prd[int'(nw_s)*PW +: PW];
               map_s[bus.in_rd[k*AW +: AW]] = bus.fl_prd[int'(nw_s)*PW +: PW];
               prev_valid_s[k]              = 1'b1;
               nw_s                         = nw_s + FPW'(1);
            end else begin
               prev_valid_s[k] = 1'b0;
            end
            // Snapshot includes this slot's own destination write.
            if (bus.in_is_br[k]) begin
               br_s[k]     = 1'b1;
               cp_idx_s[k] = alloc_base_s + CW'(nb_s);
               snap_s[k]   = map_s;
               nb_s        = nb_s + FPW'(1);
            end else begin
               br_s[k] = 1'b0;
            end
         end else begin
            prev_valid_s[k] = 1'b0;
         end
      end
   end

   // Map table and checkpoint ring pointers: reset, recovery, release and allocation.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         head_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < ARF_SIZE; i++) begin
            map_q[i] <= PW'(i);
         end
      end else if (bus.recover) begin
         head_q  <= head_rel_s;
         count_q <= {1'b0, rec_dist_s} + (CW+1)'(1);
         map_q   <= cp_q[bus.recover_cp];
      end else if (accept_s) begin
         head_q  <= head_rel_s;
         count_q <= count_rel_s + (CW+1)'(nb_s);
         map_q   <= map_s;
      end else begin
         head_q  <= head_rel_s;
         count_q <= count_rel_s;
      end
   end

   // Checkpoint storage: each accepted branch writes its snapshot to its slot.
   always_ff @(posedge clock_i) begin
      if (!reset_i && accept_s) begin
         for (int k = 0; k < RENAME_WIDTH; k++) begin
            if (br_s[k]) begin
               cp_q[cp_idx_s[k]] <= snap_s[k];
            end
         end
      end
   end

   // Output register: load on accept, hold under back-pressure, drop on recover.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         out_valid_q  <= 1'b0;
         fl_pop_q     <= '0;
         uop_valid_q  <= '0;
         prev_valid_q <= '0;
         prs1_q       <= '0;
         prs2_q       <= '0;
         prd_q        <= '0;
         prev_q       <= '0;
         cp_idx_q     <= '0;
      end else if (bus.recover) begin
         out_valid_q <= 1'b0;
         fl_pop_q    <= '0;
      end else if (accept_s) begin
         out_valid_q  <= 1'b1;
         fl_pop_q     <= nw_s;
         uop_valid_q  <= bus.in_uop_valid;
         prev_valid_q <= prev_valid_s;
         prs1_q       <= prs1_s;
         prs2_q       <= prs2_s;
         prd_q        <= prd_s;
         prev_q       <= prev_s;
         cp_idx_q     <= cp_idx_s;
      end else begin
         fl_pop_q <= '0;
         if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready       = in_ready_s;
   assign bus.fl_pop         = fl_pop_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_uop_valid  = uop_valid_q;
   assign bus.out_prev_valid = prev_valid_q;
   assign bus.out_prs1       = prs1_q;
   assign bus.out_prs2       = prs2_q;
   assign bus.out_prd        = prd_q;
   assign bus.out_prev_prd   = prev_q;
   assign bus.out_cp_idx     = cp_idx_q;

`ifdef RAT_CKPT_PERF_EN
   logic [31:0] perf_cp_q, perf_fl_q;

   // Saturating stall counters: checkpoint-only stalls and free-list stalls.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         perf_cp_q <= '0;
         perf_fl_q <= '0;
      end else begin
         if (bus.in_valid && !bus.recover && out_ok_s && fl_ok_s && !cp_ok_s
             && (perf_cp_q != 32'hFFFF_FFFF)) begin
            perf_cp_q <= perf_cp_q + 32'd1;
         end
         if (bus.in_valid && !fl_ok_s && (perf_fl_q != 32'hFFFF_FFFF)) begin
            perf_fl_q <= perf_fl_q + 32'd1;
         end
      end
   end

   assign perf_stall_cp_o = perf_cp_q;
   assign perf_stall_fl_o = perf_fl_q;
`endif

   rat_ckpt_chk #(.CW(CW), .RLW($clog2(COMMIT_WIDTH) + 1)) u_chk (
      .clk_i        (clock_i),
      .rst_i        (reset_i),
      .cp_release_i (bus.cp_release),
      .count_i      (count_q)
   );
endmodule
